// File: rtl/mdu_sequencer_if.sv
// Signal bundle between the multiply/divide sequencer, its requester and the
// shared ALU. The sequencer takes the slave view; whoever owns the request
// side and the ALU result takes the master view.
interface mdu_sequencer_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic [4:0]  alu_ctrl;
    logic        alu_sign;
    logic [31:0] alu_out;
    logic        alu_zero;

    modport slave (
        input  start, op, a, b, alu_out, alu_zero,
        output busy, done, hi, lo, alu_in1, alu_in2, alu_ctrl, alu_sign
    );

    modport master (
        output start, op, a, b, alu_out, alu_zero,
        input  busy, done, hi, lo, alu_in1, alu_in2, alu_ctrl, alu_sign
    );
endinterface

// File: rtl/mdu_sequencer.sv
// Multi-cycle 32-bit mult/multu/div/divu built on the shared ALU's add and
// subtract. Signed operations run on magnitudes and fix the signs at the end.
// Fixed latency: done rises 36 edges after the accepting edge.
module mdu_sequencer #(
    parameter logic [4:0] AND_CTRL = 5'b00000,
    parameter logic [4:0] ADD_CTRL = 5'b00010,
    parameter logic [4:0] SUB_CTRL = 5'b00110
) (
    input  logic               clk,
    input  logic               reset,
    mdu_sequencer_if.slave     bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ABS_A,
        S_ABS_B,
        S_ITER,
        S_FIX_LO,
        S_FIX_HI,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        is_div_q, is_div_d;
    logic        neg_a_q, neg_a_d;
    logic        neg_b_q, neg_b_d;
    logic        lo_zero_q, lo_zero_d;

    // Signs are latched at start because the magnitude steps overwrite a/b.
    logic        neg_lo;
    logic        carry;
    logic [31:0] rem_shift;
    logic        take_sub;
    logic [31:0] b_abs;

    assign neg_lo       = neg_a_q ^ neg_b_q;
    assign bus.busy     = (state_q != S_IDLE) && (state_q != S_DONE);
    assign bus.done     = (state_q == S_DONE);
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.alu_sign = 1'b0;

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_a_q   <= 1'b0;
            neg_b_q   <= 1'b0;
            lo_zero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_a_q   <= neg_a_d;
            neg_b_q   <= neg_b_d;
            lo_zero_q <= lo_zero_d;
        end
    end

    // Next state, register updates and the ALU port mux for each step.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_a_d   = neg_a_q;
        neg_b_d   = neg_b_q;
        lo_zero_d = lo_zero_q;

        bus.alu_in1  = '0;
        bus.alu_in2  = '0;
        bus.alu_ctrl = AND_CTRL;

        // Helpers for the iteration step: add carry-out for multiply and
        // the restoring-division trial (msb covers the 33rd remainder bit).
        carry     = (bus.alu_out < hi_q);
        rem_shift = {hi_q[30:0], lo_q[31]};
        take_sub  = hi_q[31] | !(rem_shift < b_q);
        b_abs     = neg_b_q ? bus.alu_out : b_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d      = bus.a;
                    b_d      = bus.b;
                    is_div_d = bus.op[1];
                    neg_a_d  = bus.op[0] & bus.a[31];
                    neg_b_d  = bus.op[0] & bus.b[31];
                    hi_d     = '0;
                    lo_d     = '0;
                    cnt_d    = '0;
                    state_d  = S_ABS_A;
                end
            end
            S_ABS_A: begin
                bus.alu_ctrl = SUB_CTRL;
                bus.alu_in2  = a_q;
                if (neg_a_q) a_d = bus.alu_out;
                state_d = S_ABS_B;
            end
            S_ABS_B: begin
                // Multiply shifts the multiplier out of lo; divide shifts the
                // dividend out of lo while the quotient shifts in.
                bus.alu_ctrl = SUB_CTRL;
                bus.alu_in2  = b_q;
                b_d     = b_abs;
                lo_d    = is_div_q ? a_q : b_abs;
                state_d = S_ITER;
            end
            S_ITER: begin
                if (!is_div_q) begin
                    bus.alu_ctrl = ADD_CTRL;
                    bus.alu_in1  = hi_q;
                    bus.alu_in2  = a_q;
                    if (lo_q[0]) begin
                        hi_d = {carry, bus.alu_out[31:1]};
                        lo_d = {bus.alu_out[0], lo_q[31:1]};
                    end else begin
                        hi_d = {1'b0, hi_q[31:1]};
                        lo_d = {hi_q[0], lo_q[31:1]};
                    end
                end else begin
                    bus.alu_ctrl = SUB_CTRL;
                    bus.alu_in1  = rem_shift;
                    bus.alu_in2  = b_q;
                    if (take_sub) begin
                        hi_d = bus.alu_out;
                        lo_d = {lo_q[30:0], 1'b1};
                    end else begin
                        hi_d = rem_shift;
                        lo_d = {lo_q[30:0], 1'b0};
                    end
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = S_FIX_LO;
            end
            S_FIX_LO: begin
                // lo_zero feeds the borrow into the high word of a 64-bit negate.
                bus.alu_ctrl = SUB_CTRL;
                bus.alu_in2  = lo_q;
                if (neg_lo) lo_d = bus.alu_out;
                lo_zero_d = bus.alu_zero;
                state_d   = S_FIX_HI;
            end
            S_FIX_HI: begin
                if (!is_div_q && neg_lo) begin
                    bus.alu_ctrl = ADD_CTRL;
                    bus.alu_in1  = ~hi_q;
                    bus.alu_in2  = {31'b0, lo_zero_q};
                    hi_d = bus.alu_out;
                end else if (is_div_q && neg_a_q) begin
                    // Remainder follows the dividend's sign.
                    bus.alu_ctrl = SUB_CTRL;
                    bus.alu_in2  = hi_q;
                    hi_d = bus.alu_out;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Bench for mdu_sequencer: an arithmetic reference model plus a cycle-level
// expectation of busy/done, checked every cycle, plus literal result cases.
module tb_mdu_sequencer;

    localparam logic [4:0] AND_C = 5'b00000;
    localparam logic [4:0] ADD_C = 5'b00010;
    localparam logic [4:0] SUB_C = 5'b00110;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mdu_sequencer_if bus();

    mdu_sequencer #(.AND_CTRL(AND_C), .ADD_CTRL(ADD_C), .SUB_CTRL(SUB_C)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    // External ALU: add, subtract, otherwise AND.
    assign bus.alu_out  = (bus.alu_ctrl == ADD_C) ? bus.alu_in1 + bus.alu_in2 :
                          (bus.alu_ctrl == SUB_C) ? bus.alu_in1 - bus.alu_in2 :
                                                    bus.alu_in1 & bus.alu_in2;
    assign bus.alu_zero = (bus.alu_out == 32'h0);

    int errs = 0;
    int checks = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Architectural result of each operation, from plain integer arithmetic.
    function automatic logic [63:0] mdu_ref(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [63:0] p;
        logic [31:0] q, r;
        case (op)
            2'b00: return {32'b0, a} * {32'b0, b};
            2'b01: begin
                p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                return p;
            end
            2'b10: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: begin
                if (b == 32'h0) return {a, (a[31] ? 32'h0000_0001 : 32'hFFFF_FFFF)};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {r, q};
            end
        endcase
    endfunction

    // Cycle model: k = edges since the accepting edge (0..35 busy, 36 done),
    // -1 while idle. Expected hi/lo are the result of the last accepted op.
    int k = -1;
    logic [31:0] m_hi = '0, m_lo = '0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k    <= -1;
            m_hi <= '0;
            m_lo <= '0;
        end else begin
            cyc <= cyc + 1;
            if (k < 0) begin
                if (bus.start) begin
                    {m_hi, m_lo} <= mdu_ref(bus.op, bus.a, bus.b);
                    k <= 0;
                end
            end else if (k == 36) begin
                k <= -1;
            end else begin
                k <= k + 1;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy", 32'(bus.busy), 32'(k >= 0 && k <= 35));
            chk("done", 32'(bus.done), 32'(k == 36));
            chk("alu_sign", 32'(bus.alu_sign), 32'h0);
            if (k < 0 || k == 36) begin
                chk("idle_alu_in1", bus.alu_in1, 32'h0);
                chk("idle_alu_in2", bus.alu_in2, 32'h0);
                chk("idle_alu_ctrl", 32'(bus.alu_ctrl), 32'(AND_C));
                chk("model_hi", bus.hi, m_hi);
                chk("model_lo", bus.lo, m_lo);
            end
        end
    end

    // Raise start for one edge; returns 2 time units after that edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #2;
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        @(posedge clk); #2;
        bus.start = 1'b0;
    endtask

    // Count edges until done; optionally toggle start with junk while busy.
    task automatic wait_done(input bit noise, output int edges);
        bit seen;
        seen = 0;
        edges = 0;
        for (int i = 0; i < 80 && !seen; i++) begin
            @(posedge clk); #1;
            edges++;
            if (bus.done) seen = 1;
            else if (noise && edges >= 5 && edges <= 25) begin
                bus.start = 1'($urandom_range(0, 1));
                bus.op = 2'($urandom_range(0, 3));
                bus.a = $urandom;
                bus.b = $urandom;
            end else begin
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        checks++;
        if (!seen) begin
            errs++;
            $display("FAIL done_timeout: no done within 80 edges");
        end
    endtask

    task automatic run_lit(input string name, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                           input bit noise);
        int e;
        logic [63:0] mr;
        issue(op, a, b);
        wait_done(noise, e);
        chk({name, "_latency"}, 32'(e), 32'd36);
        chk({name, "_hi"}, bus.hi, eh);
        chk({name, "_lo"}, bus.lo, el);
        mr = mdu_ref(op, a, b);
        chk({name, "_ref_hi"}, mr[63:32], eh);
        chk({name, "_ref_lo"}, mr[31:0], el);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            4: return 32'h0 - 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int e, d1, d2;
        logic [1:0] op;
        logic [31:0] ra, rb;
        logic [63:0] r;

        bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_done", 32'(bus.done), 32'h0);
        chk("rst_hi", bus.hi, 32'h0);
        chk("rst_lo", bus.lo, 32'h0);
        chk("rst_ctrl", 32'(bus.alu_ctrl), 32'(AND_C));
        #1 rst_n = 1'b1;

        run_lit("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0);
        run_lit("mult_neg3x7", 2'b01, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
        run_lit("mult_minsq", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 0);
        run_lit("mult_lozero", 2'b01, 32'h0001_0000, 32'hFFFF_0000, 32'hFFFF_FFFF, 32'h0, 0);
        run_lit("divu_100_7", 2'b10, 32'd100, 32'd7, 32'h2, 32'hE, 0);
        run_lit("div_m7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
        run_lit("div_7_m2", 2'b11, 32'd7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD, 0);
        run_lit("divu_by0", 2'b10, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 0);
        run_lit("div_by0", 2'b11, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'h1, 0);
        run_lit("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 0);

        // start pulses while busy must not disturb the running operation.
        run_lit("noise_multu", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 1);

        // Back-to-back: DONE and the following IDLE each take one cycle, so the
        // second done comes 38 edges after the first (37 cycles between them).
        issue(2'b10, 32'd100, 32'd7);
        wait_done(0, e);
        d1 = cyc;
        @(posedge clk); #2;
        bus.start = 1'b1; bus.op = 2'b11; bus.a = 32'hFFFF_FFF9; bus.b = 32'd2;
        @(posedge clk); #2;
        bus.start = 1'b0;
        wait_done(0, e);
        d2 = cyc;
        chk("b2b_gap", 32'(d2 - d1), 32'd38);
        chk("b2b_hi", bus.hi, 32'hFFFF_FFFF);
        chk("b2b_lo", bus.lo, 32'hFFFF_FFFD);

        // Asynchronous reset in the middle of the iterations (count 10).
        issue(2'b00, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (11) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(bus.busy), 32'h0);
        chk("abort_done", 32'(bus.done), 32'h0);
        chk("abort_hi", bus.hi, 32'h0);
        chk("abort_lo", bus.lo, 32'h0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        d1 = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done) d1++;
        end
        chk("abort_no_done", 32'(d1), 32'h0);
        run_lit("post_rst_3x4", 2'b00, 32'd3, 32'd4, 32'h0, 32'd12, 0);

        // Randomized operations, some with start noise while busy.
        for (int i = 0; i < 30; i++) begin
            op = 2'($urandom_range(0, 3));
            ra = pick();
            rb = pick();
            r = mdu_ref(op, ra, rb);
            issue(op, ra, rb);
            wait_done(1'($urandom_range(0, 1)), e);
            chk("rand_latency", 32'(e), 32'd36);
            chk("rand_hi", bus.hi, r[63:32]);
            chk("rand_lo", bus.lo, r[31:0]);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
